// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
   localparam int FETCH_ADDR_W = 64;
   localparam int FETCH_INSN_W = 32;
   localparam int FETCH_PC_INC = 4;
   typedef enum logic [1:0] {BOOT, RUN, REDIRECT_WAIT} fetch_state_e;
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [FETCH_INSN_W-1:0] insn;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: cache instruction port plus decode handshake seen by the fetch stage
interface fetch_if import fetch_pkg::*; #(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int INSN_W = FETCH_INSN_W
);
   logic              instruction_read;
   logic [ADDR_W-1:0] instruction_address;
   logic              i_busy;
   logic [INSN_W-1:0] instruction_response;
   logic              fetch_valid;
   logic [ADDR_W-1:0] fetch_pc;
   logic [INSN_W-1:0] fetch_instruction;
   logic              decode_ready;
   modport master (
      output instruction_read, instruction_address, fetch_valid, fetch_pc, fetch_instruction,
      input  i_busy, instruction_response, decode_ready
   );
   modport slave (
      input  instruction_read, instruction_address, fetch_valid, fetch_pc, fetch_instruction,
      output i_busy, instruction_response, decode_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: shift-register FIFO whose slot 0 is the registered head output
module fetch_queue import fetch_pkg::*; #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  entry_t                 din,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output entry_t                 head
);
   localparam int CW = $clog2(DEPTH) + 1;
   entry_t          mem     [DEPTH];
   entry_t          shifted [DEPTH];
   logic            do_pop, do_push;
   logic [CW-1:0]   wr_idx;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign wr_idx  = count - CW'(do_pop);
   assign head    = mem[0];
   // contents one slot closer to the head, used when an entry is popped
   always_comb begin
      shifted[DEPTH-1] = '0;
      for (int i = 0; i < DEPTH - 1; i++) shifted[i] = mem[i + 1];
   end
   // storage and occupancy; a flush only clears the count, stale slots are never visible
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= (do_push && CW'(i) == wr_idx) ? din : do_pop ? shifted[i] : mem[i];
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues cache fetches and queues instructions for decode
// Optional FETCH_TRACE_EN: prints each push and each redirect target (simulation only)
module fetch_stage import fetch_pkg::*; #(
   parameter int ADDR_W      = FETCH_ADDR_W,
   parameter int INSN_W      = FETCH_INSN_W,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] entry,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   fetch_if.master           bus
);
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [1:0] ST_BOOT = BOOT;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_WAIT = REDIRECT_WAIT;
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INSN_W-1:0] insn;
   } entry_t;
   logic [1:0]        state;
   logic [ADDR_W-1:0] pc, pending_pc, target;
   logic              rd, done, push, full, empty;
   logic [CW-1:0]     count;
   entry_t            din, head;
   assign target = redirect_pc & ~ADDR_W'(3);
   assign rd     = (state == ST_RUN) ? (count < CW'(QUEUE_DEPTH)) : (state == ST_WAIT);
   assign done   = rd && !bus.i_busy;
   assign push   = (state == ST_RUN) && done && !redirect_valid && !full;
   assign din    = '{pc: pc, insn: bus.instruction_response};
   assign bus.instruction_read    = rd;
   assign bus.instruction_address = pc;
   assign bus.fetch_valid         = !empty;
   assign bus.fetch_pc            = head.pc;
   assign bus.fetch_instruction   = head.insn;
   fetch_queue #(.DEPTH(QUEUE_DEPTH), .entry_t(entry_t)) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (din),
      .pop   (bus.decode_ready),
      .flush (redirect_valid),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );
   // PC sequencing: boot load, linear advance on completion, redirects deferred past a busy access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_BOOT;
         pc         <= '0;
         pending_pc <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               pc    <= redirect_valid ? target : entry;
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (redirect_valid && rd && bus.i_busy) begin
                  pending_pc <= target;
                  state      <= ST_WAIT;
               end else if (redirect_valid) begin
                  pc <= target;
               end else if (done) begin
                  pc <= pc + ADDR_W'(FETCH_PC_INC);
               end
            end
            ST_WAIT: begin
               if (done) begin
                  pc    <= redirect_valid ? target : pending_pc;
                  state <= ST_RUN;
               end else if (redirect_valid) begin
                  pending_pc <= target;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end
`ifdef FETCH_TRACE_EN
   // trace of queued instructions and redirect targets
   always_ff @(posedge clk) begin
      if (!reset && push) $display("fetch @ %x - %x", pc, bus.instruction_response);
      if (!reset && redirect_valid) $display("fetch redirect -> %x", target);
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a queue-based model
module tb_fetch_stage;
   localparam int DEPTH = 4;
   typedef struct {
      logic [63:0] pc;
      logic [31:0] insn;
   } ent_t;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] entry = '0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   int          tests = 0;
   int          fails = 0;
   bit          rnd = 1'b0;
   bit          m_booted, m_pend;
   logic [63:0] m_pc, m_pend_pc;
   ent_t        q[$];
   fetch_if #(.ADDR_W(64), .INSN_W(32)) bus ();
   fetch_stage #(.ADDR_W(64), .INSN_W(32), .QUEUE_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .entry          (entry),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus.master)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   function automatic logic [31:0] insn_of(input logic [63:0] a);
      return a[31:0] ^ 32'hC0DE_0000;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic bit m_read();
      return !m_booted ? 1'b0 : m_pend ? 1'b1 : (q.size() < DEPTH);
   endfunction
   task automatic model_reset();
      m_booted = 0; m_pend = 0; m_pc = '0; m_pend_pc = '0; q.delete();
   endtask
   task automatic model_step();
      bit rd, done;
      logic [63:0] rpc;
      rd   = m_read();
      done = rd && !bus.i_busy;
      rpc  = redirect_pc & ~64'd3;
      if (!m_booted) begin
         m_pc = redirect_valid ? rpc : entry;
         m_booted = 1;
      end else if (m_pend) begin
         if (done) begin
            m_pc = redirect_valid ? rpc : m_pend_pc;
            m_pend = 0;
         end else if (redirect_valid) m_pend_pc = rpc;
      end else if (redirect_valid) begin
         q.delete();
         if (rd && bus.i_busy) begin
            m_pend = 1;
            m_pend_pc = rpc;
         end else m_pc = rpc;
      end else begin
         if (bus.decode_ready && q.size() > 0) void'(q.pop_front());
         if (done) begin
            q.push_back('{m_pc, bus.instruction_response});
            m_pc = m_pc + 64'd4;
         end
      end
   endtask
   task automatic compare_all();
      chk("read", 64'(bus.instruction_read), 64'(m_read()));
      chk("addr", bus.instruction_address, m_pc);
      chk("valid", 64'(bus.fetch_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("head_pc", bus.fetch_pc, q[0].pc);
         chk("head_insn", 64'(bus.fetch_instruction), 64'(q[0].insn));
      end
   endtask
   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      #1;
      if (!rnd) bus.instruction_response = insn_of(m_pc);
   endtask
   task automatic set_in(input bit busy, input bit ready, input bit rv, input logic [63:0] rpc);
      bus.i_busy = busy; bus.decode_ready = ready; redirect_valid = rv; redirect_pc = rpc;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_read", 64'(bus.instruction_read), 64'd0);
      chk("rst_addr", bus.instruction_address, 64'd0);
      chk("rst_valid", 64'(bus.fetch_valid), 64'd0);
      chk("rst_fpc", bus.fetch_pc, 64'd0);
      chk("rst_finsn", 64'(bus.fetch_instruction), 64'd0);
      model_reset();
      if (!rnd) bus.instruction_response = insn_of(m_pc);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask
   initial begin
      bus.i_busy = 1'b0; bus.decode_ready = 1'b0; bus.instruction_response = '0;
      #2;
      entry = 64'h1000; set_in(0, 1, 0, 0); do_reset();
      cycle();
      chk("boot_read", 64'(bus.instruction_read), 64'd1);
      chk("boot_addr0", bus.instruction_address, 64'h1000);
      cycle();
      chk("boot_addr1", bus.instruction_address, 64'h1004);
      chk("boot_fpc0", bus.fetch_pc, 64'h1000);
      chk("boot_insn0", 64'(bus.fetch_instruction), 64'(insn_of(64'h1000)));
      cycle();
      chk("boot_addr2", bus.instruction_address, 64'h1008);
      chk("boot_fpc1", bus.fetch_pc, 64'h1004);
      set_in(0, 0, 0, 0); do_reset();
      cycle();
      repeat (4) cycle();
      chk("bp_read", 64'(bus.instruction_read), 64'd0);
      chk("bp_addr", bus.instruction_address, 64'h1010);
      chk("bp_fpc", bus.fetch_pc, 64'h1000);
      cycle();
      chk("bp_hold", 64'(bus.instruction_read), 64'd0);
      bus.decode_ready = 1'b1;
      cycle();
      chk("bp_resume", 64'(bus.instruction_read), 64'd1);
      chk("bp_resume_addr", bus.instruction_address, 64'h1010);
      chk("bp_next_fpc", bus.fetch_pc, 64'h1004);
      entry = 64'h2000; set_in(1, 1, 0, 0); do_reset();
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("busy_addr", bus.instruction_address, 64'h2000);
         chk("busy_valid", 64'(bus.fetch_valid), 64'd0);
      end
      bus.i_busy = 1'b0;
      cycle();
      chk("rel_fpc", bus.fetch_pc, 64'h2000);
      chk("rel_insn", 64'(bus.fetch_instruction), 64'(insn_of(64'h2000)));
      chk("rel_addr", bus.instruction_address, 64'h2004);
      entry = 64'h1000; set_in(0, 0, 0, 0); do_reset();
      repeat (4) cycle();
      chk("ri_pre_valid", 64'(bus.fetch_valid), 64'd1);
      set_in(0, 0, 1, 64'h3002);
      cycle();
      chk("ri_flush", 64'(bus.fetch_valid), 64'd0);
      chk("ri_addr", bus.instruction_address, 64'h3000);
      set_in(0, 0, 0, 0);
      cycle();
      chk("ri_fpc", bus.fetch_pc, 64'h3000);
      entry = 64'h4000; set_in(1, 1, 0, 0); do_reset();
      cycle(); cycle();
      set_in(1, 1, 1, 64'h5000); cycle();
      chk("rb_hold", bus.instruction_address, 64'h4000);
      chk("rb_read", 64'(bus.instruction_read), 64'd1);
      set_in(1, 1, 0, 0); cycle();
      set_in(1, 1, 1, 64'h6000); cycle();
      chk("rb_hold2", bus.instruction_address, 64'h4000);
      set_in(0, 1, 0, 0); cycle();
      chk("rb_addr", bus.instruction_address, 64'h6000);
      chk("rb_drop", 64'(bus.fetch_valid), 64'd0);
      cycle();
      chk("rb_fpc", bus.fetch_pc, 64'h6000);
      entry = 64'hFFFF_FFFF_FFFF_FFF8; set_in(0, 1, 0, 0); do_reset();
      cycle(); cycle();
      chk("wrap_top", bus.instruction_address, 64'hFFFF_FFFF_FFFF_FFFC);
      cycle();
      chk("wrap_zero", bus.instruction_address, 64'h0);
      entry = 64'h7000; set_in(0, 0, 0, 0); do_reset();
      cycle(); cycle(); cycle();
      bus.i_busy = 1'b1;
      cycle();
      chk("rr_pre_valid", 64'(bus.fetch_valid), 64'd1);
      entry = 64'h8000; do_reset();
      cycle();
      chk("rr_addr", bus.instruction_address, 64'h8000);
      chk("rr_read", 64'(bus.instruction_read), 64'd1);
      rnd = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                {$urandom, $urandom});
         bus.instruction_response = $urandom;
         if ($urandom_range(0, 299) == 0) begin
            entry = {$urandom, $urandom};
            do_reset();
         end
         cycle();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the program counter, drives the instruction-side request port of `cache`, and buffers fetched instructions in a small queue for decode. It sits between `cache` (upstream data source) and the decode stage (downstream consumer). It handles boot-time PC load from `entry`, flow-control back-pressure, and PC redirects from later stages, including redirects that arrive while a cache access is in flight.

## Interface
- `ADDR_W`, 64, PC / address width (`ADDRESS_SIZE`)
- `INSN_W`, 32, instruction width (`INSTRUCTION_SIZE`)
- `QUEUE_DEPTH`, 4, fetch-queue entries; power of two, ≥2
- `clk` in 1, single clock, all state on rising edge
- `reset` in 1, asynchronous, active-high; clears all state immediately
- `entry` in ADDR_W, boot PC, sampled in BOOT state
- `instruction_read` out 1, fetch request to cache
- `instruction_address` out ADDR_W, fetch address; equals PC register
- `i_busy` in 1, cache busy; a completion is any cycle with `instruction_read=1 && i_busy=0`
- `instruction_response` in INSN_W, instruction data, valid in completion cycle
- `redirect_valid` in 1, one-cycle redirect pulse from execute
- `redirect_pc` in ADDR_W, redirect target; bits [1:0] ignored (treated as 0)
- `fetch_valid` out 1, queue head valid
- `fetch_pc` out ADDR_W, PC of queue head
- `fetch_instruction` out INSN_W, instruction at queue head
- `decode_ready` in 1, decode accepts head when `fetch_valid && decode_ready`

## Operation
- States: BOOT, RUN, REDIRECT_WAIT.
- BOOT (reset state): `instruction_read=0`; next edge loads `pc<=entry` and moves to RUN. If `redirect_valid` is high in BOOT, `pc<=redirect_pc` instead.
- RUN: `instruction_read = (count < QUEUE_DEPTH)`. On completion: push {pc, instruction_response} and set `pc<=pc+4` (mod 2^ADDR_W; wrap from all-ones-minus-3 to 0).
- Address stability: while `instruction_read=1 && i_busy=1`, `pc` and `instruction_address` must not change.
- Redirect in RUN with `i_busy=0`: flush queue (count→0), drop any same-cycle completion, `pc<=redirect_pc`, stay in RUN.
- Redirect in RUN with `instruction_read=1 && i_busy=1`: flush queue, latch target in `pending_pc`, go to REDIRECT_WAIT. Address is held.
- REDIRECT_WAIT: `instruction_read` stays 1 at the old address. On completion, drop the data, `pc<=pending_pc`, go to RUN. A further redirect here overwrites `pending_pc`. Queue pushes are suppressed.
- Flush has priority over a simultaneous pop. Pop and push in the same cycle are legal when count<QUEUE_DEPTH.
- Full queue: `instruction_read` is deasserted, so no push can happen while full.
- Empty queue: `fetch_valid=0`. There is no bypass.

## Timing
- Reset values: `instruction_read=0`, `instruction_address=0`, `fetch_valid=0`, `fetch_pc=0`, `fetch_instruction=0`, count=0, state=BOOT.
- Reset asserted mid-access: all state clears. The cache is responsible for abandoning its own transaction.
- First request: `instruction_read` rises on the first edge after reset deasserts (BOOT→RUN).
- Completion to `fetch_valid`: 1 cycle (queue output is registered).
- Redirect to new-address request: 1 cycle when not busy. When busy, 1 cycle after the in-flight completion.
- `instruction_read` is a function of registered state and count only, with no combinational path from `decode_ready`. Consequently, at count=QUEUE_DEPTH with a pop, the request resumes on the following cycle.
- Peak throughput: one instruction per cycle when `i_busy` stays low.

## Configuration
- `FETCH_TRACE_EN` defined: each push prints `$display("fetch @ %x - %x", pc, insn)`, and each redirect prints its target. This is simulation-only.
- Without it: no display statements. RTL behaviour is identical.

## Structure
- `fetch_pkg`:
  - `fetch_state_e` (BOOT/RUN/REDIRECT_WAIT)
  - `fetch_entry_t` struct {pc, insn}
  - the PC increment constant 4
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, parameterised by depth, with ports push/pop/flush/full/empty/count and registered head output.

## Test plan
- Boot: `entry=0x1000`, `i_busy=0`, `decode_ready=1` → requests 0x1000, 0x1004, 0x1008 on consecutive cycles; `fetch_pc` lags by 1 cycle with matching instructions.
- Back-pressure: `decode_ready=0` with `QUEUE_DEPTH=4` → exactly 4 pushes, then `instruction_read=0`. Raising `decode_ready` → request resumes the next cycle at 0x1010.
- Busy hold: `i_busy` high for 5 cycles on 0x2000 → address is stable for all 5 cycles, and one entry {0x2000, data} is pushed at release.
- Redirect while idle: queue holds 3 entries, `redirect_valid` with `redirect_pc=0x3002` → `fetch_valid=0` next cycle; next request is 0x3000.
- Redirect while busy: busy on 0x4000, redirect to 0x5000, then a second redirect to 0x6000 before release → the 0x4000 data is dropped, no push occurs, and the next request is 0x6000.
- Reset mid-run: assert `reset` while busy with count=2 → all outputs go to 0 immediately. After release, fetch restarts from the current `entry`.
